// File: rtl/watch_pkg.sv
// Shared watch types: alarm FSM states, time limits and the alarm slot record.
package watch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_e;

  localparam logic [7:0] MAX_HOUR = 8'd23;
  localparam logic [7:0] MAX_MIN  = 8'd59;

  typedef struct packed {
    logic       on;
    logic [7:0] hour;
    logic [7:0] minute;
  } alarm_slot_t;

  function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/alarm_slot_match.sv
// Per-slot trigger: fires on the whole-minute second of an enabled slot's time.
module alarm_slot_match
  import watch_pkg::*;
(
  input  alarm_slot_t slot,
  input  logic [7:0]  hour,
  input  logic [7:0]  minute,
  input  logic [7:0]  second,
  output logic        fire
);

  assign fire = slot.on && (slot.hour == hour) && (slot.minute == minute) && (second == 8'd0);

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm scheduler on the 1 Hz tick: queues fired slots and shares one buzzer.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.
module alarm_scheduler
  import watch_pkg::*;
#(
  parameter int NUM_ALARMS = 4,
  parameter int RING_SEC   = 30,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                          clk1sec,
  input  logic                          rst,
  input  logic [7:0]                    hour,
  input  logic [7:0]                    minute,
  input  logic [7:0]                    second,
  input  logic                          wr_req,
  input  logic [$clog2(NUM_ALARMS)-1:0] wr_idx,
  input  logic [7:0]                    wr_hour,
  input  logic [7:0]                    wr_min,
  input  logic                          wr_on,
  output logic                          wr_ack,
  input  logic                          stop,
  input  logic                          snooze,
  output logic                          ring,
  output logic [$clog2(NUM_ALARMS)-1:0] ring_idx,
  output logic [NUM_ALARMS-1:0]         pending
);

  localparam int IW = $clog2(NUM_ALARMS);
  localparam int RW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);

  alarm_state_e              state_q, state_d;
  alarm_slot_t [NUM_ALARMS-1:0] slot_q, slot_d;
  logic [NUM_ALARMS-1:0]     pending_q, pending_d;
  logic [NUM_ALARMS-1:0]     fire, kill_mask, svc_mask, avail;
  logic [IW-1:0]             ring_idx_q, ring_idx_d, winner;
  logic [RW-1:0]             ring_cnt_q, ring_cnt_d;
  logic                      ring_q, ring_d, wr_ack_q, wr_ack_d;
  logic                      wr_fire, kill_active, svc_clr;

`ifdef ALARM_SNOOZE_EN
  localparam int SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int SW = (SNZ_TICKS > 1) ? $clog2(SNZ_TICKS) : 1;
  localparam logic [SW-1:0] SNZ_LAST = SW'(SNZ_TICKS - 1);
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
`else
  localparam int unused_snooze_min = SNOOZE_MIN;
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  // Compare uses the stored slots, so a same-edge write only affects later matches.
  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_match
    alarm_slot_match u_match (
      .slot   (slot_q[g]),
      .hour   (hour),
      .minute (minute),
      .second (second),
      .fire   (fire[g])
    );
  end

  always_comb begin
    wr_fire     = wr_req && !wr_ack_q;
    wr_ack_d    = wr_req;
    slot_d      = slot_q;
    kill_mask   = '0;
    if (wr_fire) begin
      slot_d[wr_idx] = '{on: wr_on, hour: clamp8(wr_hour, MAX_HOUR), minute: clamp8(wr_min, MAX_MIN)};
      if (!wr_on) kill_mask = NUM_ALARMS'(1) << wr_idx;
    end
    kill_active = wr_fire && !wr_on && (wr_idx == ring_idx_q);

    avail  = pending_q & ~kill_mask;
    winner = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (avail[i]) winner = IW'(i);

    state_d    = state_q;
    ring_idx_d = ring_idx_q;
    ring_cnt_d = ring_cnt_q;
    svc_clr    = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_d  = snz_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|avail) begin
          state_d    = RING;
          ring_idx_d = winner;
          ring_cnt_d = '0;
        end
      end
      RING: begin
        if (kill_active) state_d = IDLE;
        else if (stop) begin
          svc_clr = 1'b1;
          state_d = IDLE;
        end
`ifdef ALARM_SNOOZE_EN
        else if (snooze) begin
          state_d   = SNOOZE;
          snz_cnt_d = '0;
        end
`endif
        else if (ring_cnt_q == RING_LAST) begin
          svc_clr = 1'b1;  // missed alarm is dropped, not requeued
          state_d = IDLE;
        end else ring_cnt_d = ring_cnt_q + 1'b1;
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (kill_active) state_d = IDLE;
        else if (stop) begin
          svc_clr = 1'b1;
          state_d = IDLE;
        end else if (snz_cnt_q == SNZ_LAST) begin
          state_d    = RING;
          ring_cnt_d = '0;
        end else snz_cnt_d = snz_cnt_q + 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    svc_mask  = svc_clr ? (NUM_ALARMS'(1) << ring_idx_q) : '0;
    pending_d = (pending_q | fire) & ~kill_mask & ~svc_mask;
    ring_d    = (state_d == RING);
  end

  always_ff @(posedge clk1sec or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      pending_q  <= '0;
      ring_idx_q <= '0;
      ring_cnt_q <= '0;
      ring_q     <= 1'b0;
      wr_ack_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      pending_q  <= pending_d;
      ring_idx_q <= ring_idx_d;
      ring_cnt_q <= ring_cnt_d;
      ring_q     <= ring_d;
      wr_ack_q   <= wr_ack_d;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_q  <= snz_cnt_d;
`endif
    end
  end

  assign ring     = ring_q;
  assign ring_idx = ring_idx_q;
  assign pending  = pending_q;
  assign wr_ack   = wr_ack_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler: time advances one second per tick; outputs sampled 1 unit after the edge.
module tb_alarm_scheduler;

  logic       clk1sec = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] hour = '0, minute = '0, second = '0;
  logic       wr_req = 1'b0, wr_on = 1'b0, wr_ack;
  logic [1:0] wr_idx = '0;
  logic [7:0] wr_hour = '0, wr_min = '0;
  logic       stop = 1'b0, snooze = 1'b0, ring;
  logic [1:0] ring_idx;
  logic [3:0] pending;

  int n_chk = 0;
  int n_fail = 0;
  int t = 0;

  alarm_scheduler #(.NUM_ALARMS(4), .RING_SEC(30), .SNOOZE_MIN(5)) dut (
    .clk1sec(clk1sec), .rst(rst), .hour(hour), .minute(minute), .second(second),
    .wr_req(wr_req), .wr_idx(wr_idx), .wr_hour(wr_hour), .wr_min(wr_min), .wr_on(wr_on),
    .wr_ack(wr_ack), .stop(stop), .snooze(snooze), .ring(ring), .ring_idx(ring_idx),
    .pending(pending)
  );

  always #5 clk1sec = ~clk1sec;

  task automatic apply_time();
    hour   = 8'(t / 3600);
    minute = 8'((t / 60) % 60);
    second = 8'(t % 60);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    t = h * 3600 + m * 60 + s;
    apply_time();
  endtask

  // One edge samples the current time, then the clock advances a second.
  task automatic tick();
    @(posedge clk1sec);
    #1;
    t = (t + 1) % 86400;
    apply_time();
  endtask

  task automatic do_write(input logic [1:0] idx, input logic [7:0] h, input logic [7:0] m, input logic on);
    wr_idx = idx; wr_hour = h; wr_min = m; wr_on = on; wr_req = 1'b1;
    tick();
    if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL write_ack_set: wr_ack=%b want 1", wr_ack); end
    n_chk++;
    wr_req = 1'b0;
    tick();
    if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL write_ack_clr: wr_ack=%b want 0", wr_ack); end
    n_chk++;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    if (ring !== 1'b0)     begin n_fail++; $display("FAIL reset_ring: got %b want 0", ring); end
    if (ring_idx !== 2'd0) begin n_fail++; $display("FAIL reset_ring_idx: got %0d want 0", ring_idx); end
    if (pending !== 4'd0)  begin n_fail++; $display("FAIL reset_pending: got %b want 0000", pending); end
    if (wr_ack !== 1'b0)   begin n_fail++; $display("FAIL reset_wr_ack: got %b want 0", wr_ack); end
    n_chk += 4;
    #1 rst = 1'b1;
  endtask

  task automatic test_basic();
    int hi;
    set_time(7, 0, 0);
    do_write(2'd1, 8'd7, 8'd30, 1'b1);
    set_time(7, 29, 58);
    tick(); tick();
    if (pending !== 4'b0000) begin n_fail++; $display("FAIL basic_early: pending=%b want 0000", pending); end
    n_chk++;
    tick();  // edge at 07:30:00
    if (pending !== 4'b0010 || ring !== 1'b0) begin n_fail++; $display("FAIL basic_fire: pending=%b ring=%b want 0010/0", pending, ring); end
    n_chk++;
    tick();  // edge at 07:30:01
    if (ring !== 1'b1 || ring_idx !== 2'd1) begin n_fail++; $display("FAIL basic_ring: ring=%b idx=%0d want 1/1", ring, ring_idx); end
    n_chk++;
    hi = 1;
    repeat (40) begin
      tick();
      if (ring) hi++; else break;
    end
    if (hi !== 30) begin n_fail++; $display("FAIL basic_ring_len: %0d ticks want 30", hi); end
    if (pending !== 4'b0000) begin n_fail++; $display("FAIL basic_timeout_clr: pending=%b want 0000", pending); end
    n_chk += 2;
  endtask

  task automatic test_two_slots();
    set_time(5, 0, 0);
    do_write(2'd0, 8'd6, 8'd0, 1'b1);
    do_write(2'd2, 8'd6, 8'd0, 1'b1);
    set_time(5, 59, 59);
    tick(); tick();
    if (pending !== 4'b0101) begin n_fail++; $display("FAIL two_fire: pending=%b want 0101", pending); end
    n_chk++;
    tick();
    if (ring !== 1'b1 || ring_idx !== 2'd0) begin n_fail++; $display("FAIL two_first: ring=%b idx=%0d want 1/0", ring, ring_idx); end
    n_chk++;
    tick(); tick(); tick();
    stop = 1'b1;
    tick();  // stop sampled at 06:00:05
    stop = 1'b0;
    if (ring !== 1'b0 || pending !== 4'b0100) begin n_fail++; $display("FAIL two_stop: ring=%b pending=%b want 0/0100", ring, pending); end
    n_chk++;
    tick();
    if (ring !== 1'b1 || ring_idx !== 2'd2 || pending !== 4'b0100) begin
      n_fail++; $display("FAIL two_second: ring=%b idx=%0d pending=%b want 1/2/0100", ring, ring_idx, pending);
    end
    n_chk++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    if (ring !== 1'b0 || pending !== 4'b0000) begin n_fail++; $display("FAIL two_stop2: ring=%b pending=%b want 0/0000", ring, pending); end
    n_chk++;
  endtask

  task automatic test_disable_write();
    set_time(9, 0, 0);
    do_write(2'd3, 8'd10, 8'd0, 1'b1);
    set_time(9, 59, 59);
    tick(); tick(); tick(); tick();
    if (ring !== 1'b1 || ring_idx !== 2'd3) begin n_fail++; $display("FAIL dis_ringing: ring=%b idx=%0d want 1/3", ring, ring_idx); end
    n_chk++;
    wr_idx = 2'd3; wr_hour = 8'd10; wr_min = 8'd0; wr_on = 1'b0; wr_req = 1'b1;
    tick();
    if (ring !== 1'b0 || pending !== 4'b0000 || wr_ack !== 1'b1) begin
      n_fail++; $display("FAIL dis_kill: ring=%b pending=%b ack=%b want 0/0000/1", ring, pending, wr_ack);
    end
    n_chk++;
    tick();
    if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL dis_ack_hold: wr_ack=%b want 1", wr_ack); end
    n_chk++;
    wr_req = 1'b0;
    tick();
    if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL dis_ack_drop: wr_ack=%b want 0", wr_ack); end
    n_chk++;
    set_time(10, 0, 0);
    tick();
    if (pending !== 4'b0000) begin n_fail++; $display("FAIL dis_no_fire: pending=%b want 0000", pending); end
    n_chk++;
  endtask

  task automatic test_held_request();
    set_time(7, 50, 0);
    wr_idx = 2'd0; wr_hour = 8'd8; wr_min = 8'd0; wr_on = 1'b1; wr_req = 1'b1;
    tick();
    wr_hour = 8'd9;  // data changing under a held request must not be written
    tick(); tick();
    wr_req = 1'b0;
    tick();
    set_time(8, 0, 0);
    tick();
    if (pending !== 4'b0001) begin n_fail++; $display("FAIL held_first_data: pending=%b want 0001", pending); end
    n_chk++;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    set_time(9, 0, 0);
    tick();
    if (pending !== 4'b0000) begin n_fail++; $display("FAIL held_one_write: pending=%b want 0000", pending); end
    n_chk++;
  endtask

  task automatic test_clamp_and_async_reset();
    set_time(20, 0, 0);
    do_write(2'd2, 8'd30, 8'd75, 1'b1);
    set_time(23, 58, 0);
    tick();
    if (pending !== 4'b0000) begin n_fail++; $display("FAIL clamp_2358: pending=%b want 0000", pending); end
    n_chk++;
    set_time(23, 59, 0);
    tick();
    if (pending !== 4'b0100) begin n_fail++; $display("FAIL clamp_2359: pending=%b want 0100", pending); end
    n_chk++;
    tick();
    if (ring !== 1'b1 || ring_idx !== 2'd2) begin n_fail++; $display("FAIL clamp_ring: ring=%b idx=%0d want 1/2", ring, ring_idx); end
    n_chk++;
    #2 rst = 1'b0;
    #1;
    if (ring !== 1'b0 || ring_idx !== 2'd0 || pending !== 4'd0 || wr_ack !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: ring=%b idx=%0d pending=%b ack=%b want all 0", ring, ring_idx, pending, wr_ack);
    end
    n_chk++;
    #1 rst = 1'b1;
    tick();
    if (ring !== 1'b0 || pending !== 4'd0) begin n_fail++; $display("FAIL reset_hold: ring=%b pending=%b want 0/0000", ring, pending); end
    n_chk++;
  endtask

  task automatic test_snooze();
    int cnt;
    set_time(11, 0, 0);
    do_write(2'd3, 8'd12, 8'd0, 1'b1);
    set_time(11, 59, 59);
    tick(); tick(); tick();
    if (ring !== 1'b1 || ring_idx !== 2'd3) begin n_fail++; $display("FAIL snz_ring: ring=%b idx=%0d want 1/3", ring, ring_idx); end
    n_chk++;
`ifdef ALARM_SNOOZE_EN
    tick();
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    if (ring !== 1'b0 || ring_idx !== 2'd3 || pending !== 4'b1000) begin
      n_fail++; $display("FAIL snz_enter: ring=%b idx=%0d pending=%b want 0/3/1000", ring, ring_idx, pending);
    end
    n_chk++;
    cnt = 1;
    repeat (320) begin
      tick();
      if (!ring) cnt++; else break;
    end
    if (cnt !== 300 || ring_idx !== 2'd3) begin n_fail++; $display("FAIL snz_len: off %0d ticks idx=%0d want 300/3", cnt, ring_idx); end
    n_chk++;
    stop = 1'b1; snooze = 1'b1;
    tick();
    stop = 1'b0; snooze = 1'b0;
    if (ring !== 1'b0 || pending !== 4'b0000) begin n_fail++; $display("FAIL snz_stop_prio: ring=%b pending=%b want 0/0000", ring, pending); end
    n_chk++;
`else
    snooze = 1'b1;
    cnt = 1;
    repeat (40) begin
      tick();
      if (ring) cnt++; else break;
    end
    snooze = 1'b0;
    if (cnt !== 30) begin n_fail++; $display("FAIL snz_ignored: ring %0d ticks want 30", cnt); end
    if (pending !== 4'b0000) begin n_fail++; $display("FAIL snz_timeout_clr: pending=%b want 0000", pending); end
    n_chk += 2;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_two_slots();
    test_disable_write();
    test_held_request();
    test_clamp_and_async_reset();
    test_snooze();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
